// File: rtl/aclk_lcd_frame_driver.sv
// Alarm-clock LCD frame driver. It snapshots the selected time once per refresh period and streams the
// digits as ASCII characters over valid/ready, most significant digit first. It also holds the latched alarm output.
module aclk_lcd_frame_driver #(
  parameter int          NUM_DIGITS     = 4,
  parameter int          REFRESH_CYCLES = 1000,
  parameter logic [7:0]  BLANK_CHAR     = 8'h2D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    show_a,
  input  logic                    show_new_time,
  input  logic                    alarm_en,
  input  logic                    alarm_off,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] key_time,
  input  logic                    char_ready,
  output logic                    char_valid,
  output logic [7:0]              char_data,
  output logic                    char_last,
  output logic                    frame_done,
  output logic                    sound_alarm
);

  localparam int TW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pending;
  logic [TW-1:0]   shadow;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic [TW-1:0]   sel_time;
  logic            wrap;
  logic            match;
  logic            match_d;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : BLANK_CHAR;
  endfunction

  always_comb begin
    sel_time = current_time;
    if (show_a)
      sel_time = alarm_time;
    else if (show_new_time)
      sel_time = key_time;
  end

  assign wrap    = (cnt == CW'(REFRESH_CYCLES - 1));
  assign idx_nxt = idx - IW'(1);
  assign match   = alarm_en && (current_time == alarm_time);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (wrap)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      shadow     <= '0;
      idx        <= '0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
      char_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending)
            state <= LOAD;
        end
        LOAD: begin
          // The first character comes straight from the selector, so it is valid in the cycle after LOAD.
          shadow     <= sel_time;
          pending    <= 1'b0;
          idx        <= IW'(NUM_DIGITS - 1);
          char_valid <= 1'b1;
          char_data  <= to_ascii(sel_time[4*(NUM_DIGITS-1) +: 4]);
          char_last  <= (NUM_DIGITS == 1);
          state      <= SEND;
        end
        SEND: begin
          if (char_ready) begin
            if (idx != '0) begin
              idx       <= idx_nxt;
              char_data <= to_ascii(shadow[4*idx_nxt +: 4]);
              char_last <= (idx_nxt == '0);
            end else begin
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A wrap that falls in the LOAD cycle keeps the next frame queued.
      if (wrap)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_d     <= 1'b0;
      sound_alarm <= 1'b0;
    end else begin
      match_d <= match;
      if (alarm_off || !alarm_en)
        sound_alarm <= 1'b0;
      else if (match && !match_d)
        sound_alarm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aclk_lcd_frame_driver.sv
// Directed bench for aclk_lcd_frame_driver with NUM_DIGITS=4 and REFRESH_CYCLES=8.
module tb_aclk_lcd_frame_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        show_a = 1'b0;
  logic        show_new_time = 1'b0;
  logic        alarm_en = 1'b0;
  logic        alarm_off = 1'b0;
  logic [15:0] alarm_time = 16'h0000;
  logic [15:0] current_time = 16'h0000;
  logic [15:0] key_time = 16'h0000;
  logic        char_ready = 1'b1;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_last;
  logic        frame_done;
  logic        sound_alarm;

  int n_checks = 0;
  int n_fail   = 0;

  aclk_lcd_frame_driver #(
    .NUM_DIGITS    (4),
    .REFRESH_CYCLES(8),
    .BLANK_CHAR    (8'h2D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .show_a       (show_a),
    .show_new_time(show_new_time),
    .alarm_en     (alarm_en),
    .alarm_off    (alarm_off),
    .alarm_time   (alarm_time),
    .current_time (current_time),
    .key_time     (key_time),
    .char_ready   (char_ready),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_last    (char_last),
    .frame_done   (frame_done),
    .sound_alarm  (sound_alarm)
  );

  always #5 clk = ~clk;

  // Advances on falling edges until char_valid equals lvl, bounded.
  task automatic wait_valid(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (char_valid === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Captures one whole frame with ready held high; optionally changes time inputs after the first char.
  task automatic collect(input bit chg, output logic [3:0][7:0] d, output logic [3:0] l,
                         output logic [3:0] v, output logic fd, output logic fd2, output bit ok);
    bit ok0;
    wait_valid(1'b0, ok0);
    wait_valid(1'b1, ok);
    ok = ok && ok0;
    d = '0; l = '0; v = '0; fd = 1'b0; fd2 = 1'b0;
    if (!ok) return;
    for (int i = 0; i < 4; i++) begin
      d[3-i] = char_data;
      l[3-i] = char_last;
      v[3-i] = char_valid;
      if (chg && i == 0) begin
        current_time = 16'h5678;
        key_time     = 16'h0000;
      end
      @(negedge clk);
    end
    fd = frame_done;
    @(negedge clk);
    fd2 = frame_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", char_valid); end
    n_checks++; if (char_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", char_data); end
    n_checks++; if (char_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", char_last); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_checks++; if (sound_alarm !== 1'b0) begin n_fail++; $display("FAIL reset_sound got %b want 0", sound_alarm); end
    reset = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [3:0][7:0] exp, input bit chg);
    logic [3:0][7:0] d;
    logic [3:0] l, v;
    logic fd, fd2;
    bit ok;
    collect(chg, d, l, v, fd, fd2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout got no frame want frame", name); return; end
    for (int i = 3; i >= 0; i--) begin
      n_checks++;
      if (d[i] !== exp[i]) begin n_fail++; $display("FAIL %s_char%0d got %h want %h", name, 3-i, d[i], exp[i]); end
    end
    n_checks++; if (l !== 4'b0001) begin n_fail++; $display("FAIL %s_last got %b want 0001", name, l); end
    n_checks++; if (v !== 4'b1111) begin n_fail++; $display("FAIL %s_valid got %b want 1111", name, v); end
    n_checks++; if (fd !== 1'b1) begin n_fail++; $display("FAIL %s_frame_done got %b want 1", name, fd); end
    n_checks++; if (fd2 !== 1'b0) begin n_fail++; $display("FAIL %s_frame_done_pulse got %b want 0", name, fd2); end
  endtask

  task automatic test_current_frame();
    show_a = 1'b0; show_new_time = 1'b0; char_ready = 1'b1;
    current_time = 16'h1234; key_time = 16'h8888; alarm_time = 16'h9999;
    check_frame("current", {8'h31, 8'h32, 8'h33, 8'h34}, 1'b0);
  endtask

  task automatic test_priority();
    show_a = 1'b1; show_new_time = 1'b1;
    alarm_time = 16'h0705; key_time = 16'h1111;
    check_frame("priority", {8'h30, 8'h37, 8'h30, 8'h35}, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Two consecutive frames must both arrive whole.
    show_a = 1'b0; show_new_time = 1'b0; current_time = 16'h0918;
    check_frame("b2b_a", {8'h30, 8'h39, 8'h31, 8'h38}, 1'b0);
    check_frame("b2b_b", {8'h30, 8'h39, 8'h31, 8'h38}, 1'b0);
  endtask

  task automatic test_backpressure();
    bit ok, ok0;
    show_a = 1'b0; show_new_time = 1'b0; current_time = 16'h1234;
    char_ready = 1'b0;
    wait_valid(1'b0, ok0);
    wait_valid(1'b1, ok);
    n_checks++;
    if (!(ok && ok0)) begin n_fail++; $display("FAIL bp_timeout got no frame want frame"); char_ready = 1'b1; return; end
    n_checks++; if (char_data !== 8'h31) begin n_fail++; $display("FAIL bp_char0 got %h want 31", char_data); end
    char_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (char_data !== 8'h32) begin n_fail++; $display("FAIL bp_char1 got %h want 32", char_data); end
    char_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h32 || char_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=32 l=0", k, char_valid, char_data, char_last);
      end
    end
    char_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (char_data !== 8'h33) begin n_fail++; $display("FAIL bp_char2 got %h want 33", char_data); end
    @(negedge clk);
    n_checks++;
    if (char_data !== 8'h34 || char_last !== 1'b1) begin
      n_fail++; $display("FAIL bp_char3 got d=%h l=%b want d=34 l=1", char_data, char_last);
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b1 || char_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_done got fd=%b v=%b want fd=1 v=0", frame_done, char_valid);
    end
  endtask

  task automatic test_key_midframe();
    show_a = 1'b0; show_new_time = 1'b1; key_time = 16'h9A0F; current_time = 16'h1234;
    check_frame("key", {8'h39, 8'h2D, 8'h30, 8'h2D}, 1'b1);
  endtask

  task automatic test_alarm();
    show_a = 1'b0; show_new_time = 1'b0;
    alarm_time = 16'h0700; current_time = 16'h0659; alarm_en = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (sound_alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_pre got %b want 0", sound_alarm); end
    current_time = 16'h0700;
    @(negedge clk);
    n_checks++; if (sound_alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_set got %b want 1", sound_alarm); end
    @(negedge clk);
    n_checks++; if (sound_alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_latched got %b want 1", sound_alarm); end
    alarm_off = 1'b1;
    @(negedge clk);
    n_checks++; if (sound_alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_ack got %b want 0", sound_alarm); end
    alarm_off = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (sound_alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_no_rearm%0d got %b want 0", k, sound_alarm); end
    end
    alarm_en = 1'b0; current_time = 16'h0659;
    repeat (2) @(negedge clk);
    current_time = 16'h0700;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (sound_alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_disabled%0d got %b want 0", k, sound_alarm); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok, ok0;
    int n;
    show_a = 1'b0; show_new_time = 1'b0; current_time = 16'h1234; char_ready = 1'b1;
    wait_valid(1'b0, ok0);
    wait_valid(1'b1, ok);
    n_checks++;
    if (!(ok && ok0)) begin n_fail++; $display("FAIL rst_mid_timeout got no frame want frame"); return; end
    repeat (2) @(negedge clk);
    n_checks++; if (char_data !== 8'h33) begin n_fail++; $display("FAIL rst_mid_char2 got %h want 33", char_data); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (char_valid !== 1'b0 || char_data !== 8'h00 || char_last !== 1'b0 || frame_done !== 1'b0 || sound_alarm !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got v=%b d=%h l=%b fd=%b s=%b want all 0",
                         char_valid, char_data, char_last, frame_done, sound_alarm);
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (char_valid === 1'b1) begin n = k; break; end
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL rst_latency got %0d want 10", n); end
    n_checks++; if (char_data !== 8'h31) begin n_fail++; $display("FAIL rst_first_char got %h want 31", char_data); end
  endtask

  initial begin
    test_reset();
    test_current_frame();
    test_priority();
    test_back_to_back();
    test_backpressure();
    test_key_midframe();
    test_alarm();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
